fetch_stage: RTL

//  IF stage plus IF/ID pipeline register of the async-memory pipeline.

---
 rtl/fetch_stage.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// IF stage plus IF/ID pipeline register for a pipeline fed by a variable-latency instruction memory.
// One request outstanding at a time; the returned word is buffered before entering IF/ID.
module fetch_stage #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            StallF,
  input  logic            StallD,
  input  logic            FlushD,
  input  logic [1:0]      PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  input  logic [XLEN-1:0] ALUResultE,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            ValidD
);

  typedef enum logic [1:0] {FETCH, WAIT, DROP} state_t;

  state_t            r_state;
  state_t            w_stateNext;
  logic [XLEN-1:0]   r_pcF;
  logic [XLEN-1:0]   r_reqPc;
  logic [31:0]       r_fbufInstr;
  logic [XLEN-1:0]   r_fbufPc;
  logic              r_fbufValid;

  logic              w_redir;
  logic [XLEN-1:0]   w_target;
  logic              w_accept;
  logic              w_capture;
  logic              w_consume;

  // jalr targets have bit 0 cleared; 2'b11 behaves like a branch/jal redirect
  assign w_redir   = (PCSrcE != 2'b00);
  assign w_target  = (PCSrcE == 2'b10) ? {ALUResultE[XLEN-1:1], 1'b0} : PCTargetE;
  assign imem_req  = rst_n & (r_state == FETCH) & ~r_fbufValid & ~StallF & ~w_redir;
  assign imem_addr = r_pcF;
  assign w_accept  = imem_req & imem_ready;
  assign w_consume = ~FlushD & ~StallD & r_fbufValid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= FETCH;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_capture   = 1'b0;
    case (r_state)
      FETCH: begin
        if (w_accept) begin
          w_stateNext = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          w_stateNext = FETCH;
          w_capture   = ~w_redir;
        end else if (w_redir) begin
          w_stateNext = DROP;
        end
      end
      DROP: begin
        if (imem_rvalid) begin
          w_stateNext = FETCH;
        end
      end
      default: begin
        w_stateNext = FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pcF   <= RESET_PC;
      r_reqPc <= '0;
    end else if (w_redir) begin
      r_pcF <= w_target;
    end else if (w_accept) begin
      r_reqPc <= r_pcF;
      r_pcF   <= r_pcF + XLEN'(4);
    end
  end

  // A redirect invalidates the buffered word even if it arrived this same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fbufInstr <= '0;
      r_fbufPc    <= '0;
      r_fbufValid <= 1'b0;
    end else begin
      if (w_capture) begin
        r_fbufInstr <= imem_rdata;
        r_fbufPc    <= r_reqPc;
      end
      if (w_redir) begin
        r_fbufValid <= 1'b0;
      end else if (w_capture) begin
        r_fbufValid <= 1'b1;
      end else if (w_consume) begin
        r_fbufValid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      InstrD   <= NOP_INSTR;
      PCD      <= '0;
      PCPlus4D <= '0;
      ValidD   <= 1'b0;
    end else if (FlushD) begin
      InstrD   <= NOP_INSTR;
      PCD      <= '0;
      PCPlus4D <= '0;
      ValidD   <= 1'b0;
    end else if (StallD) begin
      InstrD   <= InstrD;
      PCD      <= PCD;
      PCPlus4D <= PCPlus4D;
      ValidD   <= ValidD;
    end else if (r_fbufValid) begin
      InstrD   <= r_fbufInstr;
      PCD      <= r_fbufPc;
      PCPlus4D <= r_fbufPc + XLEN'(4);
      ValidD   <= 1'b1;
    end else begin
      InstrD   <= NOP_INSTR;
      PCD      <= '0;
      PCPlus4D <= '0;
      ValidD   <= 1'b0;
    end
  end

endmodule
